// File: rtl/photon_event_tagger_if.sv
// Event readout channel of the photon tagger: FWFT data/valid with consumer-driven ready.
interface photon_event_tagger_if #(
  parameter int DW = 26
);
  logic [DW-1:0] ev_data;
  logic          ev_valid;
  logic          ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/photon_event_tagger.sv
// Timestamps detA/detB pulses into an FWFT event FIFO (with wrap markers and drop counting)
// and accumulates per-bin photon counts over a programmable gate window.
module photon_event_tagger #(
  parameter int TS_WIDTH   = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_out,
  input  logic                 reset,
  input  logic                 detA,
  input  logic                 detB,
  photon_event_tagger_if.master ev,
  output logic [7:0]           ovf_cnt,
  input  logic                 gate_start,
  input  logic [CNT_WIDTH-1:0] gate_len,
  output logic [CNT_WIDTH-1:0] cntA,
  output logic [CNT_WIDTH-1:0] cntB,
  output logic [CNT_WIDTH-1:0] cntAB,
  output logic                 counts_valid,
  output logic                 gate_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TS_WIDTH + 2;

  // ---------------- timestamp ----------------
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_WIDTH'(1);
  end

  // ---------------- event FIFO ----------------
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          empty, full, push, pop, push_ok;
  logic [DW-1:0] push_word;

  // A word at ts==all-ones doubles as the wrap marker, detection or not.
  assign push      = detA | detB | (&ts_q);
  assign push_word = {ts_q, detB, detA};
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = !empty && ev.ev_ready;
  assign push_ok   = push && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
    if (pop)     rptr_d = rptr_q + (AW+1)'(1);
    if (push && !push_ok && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // When full, the write slot aliases the head; the head is read out before the edge overwrites it.
  always_ff @(posedge clk_out) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_word;
  end

  assign ev.ev_valid = !empty;
  assign ev.ev_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign ovf_cnt     = ovf_q;

  // ---------------- gate counter FSM ----------------
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnta_q, cnta_d, cntb_q, cntb_d, cntab_q, cntab_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnta_d  = cnta_q;
    cntb_d  = cntb_q;
    cntab_d = cntab_q;
    case (state_q)
      IDLE: begin
        if (gate_start) begin
          rem_d   = gate_len;
          cnta_d  = '0;
          cntb_d  = '0;
          cntab_d = '0;
          state_d = (gate_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cnta_d  = sat_inc(cnta_q, detA);
        cntb_d  = sat_inc(cntb_q, detB);
        cntab_d = sat_inc(cntab_q, detA & detB);
        rem_d   = rem_q - CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnta_q  <= '0;
      cntb_q  <= '0;
      cntab_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnta_q  <= cnta_d;
      cntb_q  <= cntb_d;
      cntab_q <= cntab_d;
    end
  end

  assign cntA         = cnta_q;
  assign cntB         = cntb_q;
  assign cntAB        = cntab_q;
  assign counts_valid = (state_q == DONE);
  assign gate_busy    = (state_q == RUN);
endmodule

// File: tb/tb_photon_event_tagger.sv
// Randomized + directed bench for photon_event_tagger against a queue/window reference model.
module tb_photon_event_tagger;
  localparam int TW = 4;
  localparam int FD = 16;
  localparam int CW = 8;
  localparam int TSMAX = (1 << TW) - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk_out = 1'b0;
  logic reset;
  logic detA, detB, gate_start;
  logic [CW-1:0] gate_len;
  logic [7:0]    ovf_cnt;
  logic [CW-1:0] cntA, cntB, cntAB;
  logic          counts_valid, gate_busy;

  photon_event_tagger_if #(.DW(TW+2)) evif();

  photon_event_tagger #(.TS_WIDTH(TW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk_out(clk_out), .reset(reset), .detA(detA), .detB(detB), .ev(evif),
    .ovf_cnt(ovf_cnt), .gate_start(gate_start), .gate_len(gate_len),
    .cntA(cntA), .cntB(cntB), .cntAB(cntAB),
    .counts_valid(counts_valid), .gate_busy(gate_busy)
  );

  always #5 clk_out = ~clk_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: event words as a queue, gate as an absolute cycle window.
  int     q[$];
  int     m_ts, m_ovf, m_a, m_b, m_ab;
  longint cyc, g_lo, g_hi, g_done;

  function automatic bit in_win();
    return (cyc >= g_lo) && (cyc <= g_hi);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_ovf = 0; m_a = 0; m_b = 0; m_ab = 0;
    cyc = 0; g_lo = 1; g_hi = 0; g_done = -1;
  endtask

  // Called at a negedge: check current outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic a, input logic b, input logic rdy, input logic gs, input int glen);
    bit pop, pushw;
    chk("ev_valid", evif.ev_valid, q.size() != 0);
    chk("ev_data", evif.ev_data, (q.size() != 0) ? q[0] : 0);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("gate_busy", gate_busy, in_win());
    chk("counts_valid", counts_valid, cyc == g_done);
    chk("cntA", cntA, m_a);
    chk("cntB", cntB, m_b);
    chk("cntAB", cntAB, m_ab);
    detA = a; detB = b; evif.ev_ready = rdy; gate_start = gs; gate_len = CW'(glen);
    pop   = (q.size() != 0) && rdy;
    pushw = a || b || (m_ts == TSMAX);
    if (pop) void'(q.pop_front());
    if (pushw) begin
      if (q.size() < FD) q.push_back((m_ts << 2) | (int'(b) << 1) | int'(a));
      else if (m_ovf < 255) m_ovf++;
    end
    if (in_win()) begin
      if (a && m_a < CMAX)       m_a++;
      if (b && m_b < CMAX)       m_b++;
      if (a && b && m_ab < CMAX) m_ab++;
    end
    if (gs && cyc > g_done) begin
      m_a = 0; m_b = 0; m_ab = 0;
      g_lo = cyc + 1; g_hi = cyc + glen; g_done = cyc + glen + 1;
    end
    m_ts = (m_ts + 1) % (TSMAX + 1);
    cyc++;
    @(negedge clk_out);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    detA = 0; detB = 0; evif.ev_ready = 0; gate_start = 0; gate_len = '0;
    #1;
    chk("rst_busy", gate_busy, 0);
    chk("rst_cv", counts_valid, 0);
    chk("rst_cntA", cntA, 0);
    chk("rst_cntB", cntB, 0);
    chk("rst_cntAB", cntAB, 0);
    chk("rst_valid", evif.ev_valid, 0);
    chk("rst_data", evif.ev_data, 0);
    chk("rst_ovf", ovf_cnt, 0);
    @(negedge clk_out);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    detA = 0; detB = 0; evif.ev_ready = 0; gate_start = 0; gate_len = '0;
    model_reset();
    @(negedge clk_out);

    // Two single detections with a ready consumer.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k == 6)  chk("det_a_word", evif.ev_data, (5 << 2) | 1);
      if (k == 7)  chk("det_a_once", evif.ev_valid, 0);
      if (k == 10) chk("det_b_word", evif.ev_data, (9 << 2) | 2);
      step(k == 5, k == 9, 1, 0, 0);
    end

    // Overfill with ready low, then push while full alongside a pop, then drain.
    do_reset();
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0);
    chk("ovf_after_fill", ovf_cnt, 4);
    step(1, 0, 1, 0, 0);
    chk("ovf_full_pop", ovf_cnt, 4);
    chk("full_valid", evif.ev_valid, 1);
    for (int k = 0; k < 30; k++) step(0, 0, 1, 0, 0);

    // Idle wrap markers, then a detection landing on the wrap cycle.
    for (int k = 0; k < 40; k++) step(0, 0, 1, 0, 0);
    while (m_ts != TSMAX) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("wrap_det_word", evif.ev_data, (TSMAX << 2) | 1);
    step(0, 0, 1, 0, 0);
    chk("wrap_no_marker", evif.ev_valid, 0);

    // Gate of 10 cycles with a mid-gate start attempt and a detection just past the window.
    for (int k = 0; k < 14; k++) begin
      if (k == 11) begin
        chk("gate_cv", counts_valid, 1);
        chk("gate_cntA", cntA, 4);
        chk("gate_cntB", cntB, 3);
        chk("gate_cntAB", cntAB, 1);
      end
      step((k >= 1 && k <= 3) || k == 6 || k == 11, k == 4 || k == 5 || k == 6, 1,
           k == 0 || k == 5, (k == 0) ? 10 : 3);
    end

    // Zero-length gate.
    step(1, 1, 1, 1, 0);
    chk("gate0_cv", counts_valid, 1);
    chk("gate0_cntA", cntA, 0);
    step(0, 0, 1, 0, 0);

    // Reset asserted in the middle of a gate.
    step(0, 0, 1, 1, 10);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 0);
    chk("mid_busy", gate_busy, 1);
    do_reset();

    // Random traffic under several consumer ready rates.
    for (int seg = 0; seg < 4; seg++) begin
      int rp;
      rp = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 0 : 10;
      for (int k = 0; k < 1000; k++)
        step($urandom_range(99) < 30, $urandom_range(99) < 30, $urandom_range(99) < rp,
             $urandom_range(99) < 4, $urandom_range(20));
    end
    chk("ovf_saturated", ovf_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
